riscv_issue_ctrl: RTL

// - Issue controller between decode and riscv_exec: holds the one-entry issue register feeding exec.
// - Tracks in-flight multi-cycle (long) results in a 32-entry register scoreboard and stalls dependent instrs.
// - Squashes wrong-path instrs for FLUSH_CYCLES decode beats after an exec branch_request.

---
 rtl/riscv_issue_ctrl_if.sv | 44 ++++
 rtl/riscv_issue_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/riscv_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// riscv_issue_ctrl_if
// Decode-to-issue handshake bundle. Decode drives one instruction per cycle
// with its payload; the issue controller answers with accept in the same
// cycle.
//
// Signals
//   dec_valid   decode presents an instruction this cycle
//   dec_accept  instruction consumed this cycle (combinational from the ctrl)
//   dec_long    instruction is multi-cycle (result arrives later)
//   dec_instr   one-hot instruction class (58 bits)
//   dec_opcode  raw instruction word
//   dec_pc      instruction PC
//   dec_rd_idx  destination register
//   dec_ra_idx  source register 1
//   dec_rb_idx  source register 2
//
// Modports
//   master  decode side (drives payload, samples accept)
//   slave   issue-controller side
// ---------------------------------------------------------------------------
interface riscv_issue_ctrl_if;
    logic        dec_valid;
    logic        dec_accept;
    logic        dec_long;
    logic [57:0] dec_instr;
    logic [31:0] dec_opcode;
    logic [31:0] dec_pc;
    logic [4:0]  dec_rd_idx;
    logic [4:0]  dec_ra_idx;
    logic [4:0]  dec_rb_idx;

    modport master (
        output dec_valid, dec_long, dec_instr, dec_opcode, dec_pc,
               dec_rd_idx, dec_ra_idx, dec_rb_idx,
        input  dec_accept
    );

    modport slave (
        input  dec_valid, dec_long, dec_instr, dec_opcode, dec_pc,
               dec_rd_idx, dec_ra_idx, dec_rb_idx,
        output dec_accept
    );
endinterface

// File: rtl/riscv_issue_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_issue_ctrl
// Issue controller between decode and exec. Holds the single issue register
// feeding exec, tracks in-flight long (multi-cycle) results in a 32-entry
// register scoreboard to stall RAW/WAW-dependent instructions, and squashes
// wrong-path decode beats after an exec branch redirect.
//
// Parameters
//   MAX_LONG      max long ops in flight (1..15)
//   FLUSH_CYCLES  valid decode beats dropped after a redirect (0..7)
//
// Optional feature (macro RISCV_ISSUE_BYPASS_EN)
//   Defined:   a long_done_i in the current cycle releases its register for
//              the hazard check, so a dependent instruction issues the same
//              cycle its result returns.
//   Undefined: hazard uses the registered scoreboard only.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   dec                     decode handshake (riscv_issue_ctrl_if.slave)
//   exec_stall_i            exec cannot take a new instr; hold issue register
//   branch_request_i        exec redirect this cycle
//   long_done_i/_idx_i      long result written back, and its rd
//   opcode_*_o              registered issue-register payload to exec
//   long_busy_o             long-op counter at MAX_LONG
//   err_o                   sticky: completion for a non-pending rd or underflow
// ---------------------------------------------------------------------------
module riscv_issue_ctrl #(
    parameter int MAX_LONG     = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    riscv_issue_ctrl_if.slave   dec,
    input  logic                exec_stall_i,
    input  logic                branch_request_i,
    input  logic                long_done_i,
    input  logic [4:0]          long_done_idx_i,
    output logic                opcode_valid_o,
    output logic [57:0]         opcode_instr_o,
    output logic [31:0]         opcode_opcode_o,
    output logic [31:0]         opcode_pc_o,
    output logic [4:0]          opcode_rd_idx_o,
    output logic [4:0]          opcode_ra_idx_o,
    output logic [4:0]          opcode_rb_idx_o,
    output logic                long_busy_o,
    output logic                err_o
);

    localparam int             CW      = $clog2(MAX_LONG + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_LONG);
    localparam logic [2:0]     FLUSH_N = 3'(FLUSH_CYCLES);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t        state;
    logic [2:0]    flush_cnt;
    logic [31:0]   pending;
    logic [CW-1:0] long_cnt;

    logic [31:0]   done_mask;
    logic [31:0]   set_mask;
    logic [31:0]   hazard_pending;
    logic          hazard;
    logic          accept_run;
    logic          drop_beat;
    logic          set_long;
    logic          done_ok;
    logic          done_err;
    logic          first_beat_done;

    assign long_busy_o = (long_cnt == MAX_CNT);

    assign done_mask = long_done_i ? (32'd1 << long_done_idx_i) : 32'd0;
    assign set_mask  = set_long    ? (32'd1 << dec.dec_rd_idx)  : 32'd0;

`ifdef RISCV_ISSUE_BYPASS_EN
    assign hazard_pending = pending & ~done_mask;
`else
    assign hazard_pending = pending;
`endif

    // Register 0 can never be pending because set_long excludes rd == 0.
    assign hazard = hazard_pending[dec.dec_ra_idx]
                  | hazard_pending[dec.dec_rb_idx]
                  | hazard_pending[dec.dec_rd_idx];

    assign accept_run = dec.dec_valid && (state == RUN) && !branch_request_i
                     && !exec_stall_i && !hazard && !(dec.dec_long && long_busy_o);

    // Wrong-path beats are consumed silently while flushing.
    assign drop_beat      = dec.dec_valid && (state == FLUSH) && !branch_request_i;
    assign dec.dec_accept = accept_run || drop_beat;

    assign set_long = accept_run && dec.dec_long && (dec.dec_rd_idx != 5'd0);
    assign done_ok  = long_done_i && pending[long_done_idx_i] && (long_cnt != '0);
    assign done_err = long_done_i && !done_ok;

    // The beat concurrent with a redirect is flush beat 1; with a one-beat
    // flush that already completes the flush, so no FLUSH state is needed.
    assign first_beat_done = dec.dec_valid && (FLUSH_N == 3'd1);

    // NOTE: every state element below is assigned with <= so all flops update
    // from the same pre-edge values; blocking = here would create ordering races.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= RUN;
            flush_cnt       <= 3'd0;
            pending         <= 32'd0;
            long_cnt        <= '0;
            err_o           <= 1'b0;
            opcode_valid_o  <= 1'b0;
            opcode_instr_o  <= 58'd0;
            opcode_opcode_o <= 32'd0;
            opcode_pc_o     <= 32'd0;
            opcode_rd_idx_o <= 5'd0;
            opcode_ra_idx_o <= 5'd0;
            opcode_rb_idx_o <= 5'd0;
        end else begin
            // Flush sequencing: only valid decode beats advance the count.
            if (branch_request_i) begin
                if ((FLUSH_N != 3'd0) && !first_beat_done) begin
                    state     <= FLUSH;
                    flush_cnt <= {2'b00, dec.dec_valid};
                end else begin
                    state     <= RUN;
                    flush_cnt <= 3'd0;
                end
            end else if ((state == FLUSH) && dec.dec_valid) begin
                if (flush_cnt + 3'd1 == FLUSH_N) begin
                    state     <= RUN;
                    flush_cnt <= 3'd0;
                end else begin
                    flush_cnt <= flush_cnt + 3'd1;
                end
            end

            // Issue register: a redirect kills it even while exec stalls.
            if (accept_run) begin
                opcode_valid_o  <= 1'b1;
                opcode_instr_o  <= dec.dec_instr;
                opcode_opcode_o <= dec.dec_opcode;
                opcode_pc_o     <= dec.dec_pc;
                opcode_rd_idx_o <= dec.dec_rd_idx;
                opcode_ra_idx_o <= dec.dec_ra_idx;
                opcode_rb_idx_o <= dec.dec_rb_idx;
            end else if (branch_request_i || !exec_stall_i) begin
                opcode_valid_o  <= 1'b0;
            end

            // Scoreboard: clear first, then set, so a same-index set wins.
            pending <= (pending & ~(done_ok ? done_mask : 32'd0)) | set_mask;

            case ({set_long, done_ok})
                2'b10:   long_cnt <= long_cnt + 1'b1;
                2'b01:   long_cnt <= long_cnt - 1'b1;
                default: long_cnt <= long_cnt;
            endcase

            if (done_err) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
